// File: rtl/wallace_tree_multiplier_pkg.sv
// Shared constants and elaboration-time helpers describing the Wallace reduction
// schedule: per-layer column heights and flat offsets into the node vector.
package wallace_tree_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int PROD_WIDTH = 2 * WIDTH_DEFAULT;

  // Column heights packed as 8-bit fields, enough for 16 columns of height <= 8.
  typedef logic [16*8-1:0] heights_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int get_h(input heights_t hv, input int c);
    return int'(hv[c*8 +: 8]);
  endfunction

  function automatic int fa_of(input int h);
    return h / 3;
  endfunction

  function automatic int ha_of(input int h);
    return (h % 3 == 2) ? 1 : 0;
  endfunction

  function automatic heights_t init_heights(input int w);
    heights_t hv = '0;
    for (int c = 0; c < 2 * w; c++) begin
      hv[c*8 +: 8] = 8'((c < w) ? c + 1 : 2 * w - 1 - c);
    end
    return hv;
  endfunction

  function automatic int max_height(input int w, input heights_t hv);
    int m = 0;
    for (int c = 0; c < 2 * w; c++) begin
      if (get_h(hv, c) > m) m = get_h(hv, c);
    end
    return m;
  endfunction

  // One Wallace layer: sums stay, carries move up a column, the top carry is dropped.
  function automatic heights_t step_heights(input int w, input heights_t hv);
    heights_t nv = '0;
    int h;
    int n;
    for (int c = 0; c < 2 * w; c++) begin
      h = get_h(hv, c);
      n = h - 2 * fa_of(h) - ha_of(h);
      if (c > 0) n = n + fa_of(get_h(hv, c - 1)) + ha_of(get_h(hv, c - 1));
      nv[c*8 +: 8] = 8'(n);
    end
    return nv;
  endfunction

  function automatic heights_t heights_at(input int w, input int l);
    heights_t hv = init_heights(w);
    for (int k = 0; k < l; k++) hv = step_heights(w, hv);
    return hv;
  endfunction

  function automatic int num_layers(input int w);
    heights_t hv = init_heights(w);
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      if (max_height(w, hv) > 2) begin
        hv = step_heights(w, hv);
        n++;
      end
    end
    return n;
  endfunction

  function automatic int col_height(input int w, input int l, input int c);
    return (c < 2 * w) ? get_h(heights_at(w, l), c) : 0;
  endfunction

  function automatic int fa_count(input int w, input int l, input int c);
    return fa_of(col_height(w, l, c));
  endfunction

  function automatic int ha_count(input int w, input int l, input int c);
    return ha_of(col_height(w, l, c));
  endfunction

  function automatic int col_base(input int w, input int l, input int c);
    int b = 0;
    for (int k = 0; k < l; k++) begin
      for (int cc = 0; cc < 2 * w; cc++) b += col_height(w, k, cc);
    end
    for (int cc = 0; cc < c; cc++) b += col_height(w, l, cc);
    return b;
  endfunction

  // Next-layer column c+1 holds its own sums and pass bits first, then incoming carries.
  function automatic int carry_slot(input int w, input int l, input int c);
    return col_base(w, l + 1, c + 1) + col_height(w, l, c + 1)
           - 2 * fa_count(w, l, c + 1) - ha_count(w, l, c + 1);
  endfunction

endpackage

// File: rtl/wallace_tree_multiplier_full_adder.sv
// Single-bit full adder; also serves as a half adder with cin tied low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_tree_multiplier.sv
// Unsigned WIDTHxWIDTH Wallace-tree multiplier with a ripple final adder and a
// one-cycle registered product plus valid flag.
module wallace_tree_multiplier
  import wallace_tree_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                A,
  input  logic [WIDTH-1:0]                B,
  input  logic                            in_valid,
  output logic [prod_width(WIDTH)-1:0]    P,
  output logic                            out_valid
);

  localparam int PW     = prod_width(WIDTH);
  localparam int LAYERS = num_layers(WIDTH);
  localparam int NODES  = col_base(WIDTH, LAYERS + 1, 0);

  // Every bit of every layer lives in one flat vector, located via col_base().
  logic [NODES-1:0] node;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
      assign node[col_base(WIDTH, 0, i + j) + ((i + j < WIDTH) ? i : i - (i + j - WIDTH + 1))] = A[j] & B[i];
    end
  end

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    for (genvar c = 0; c < PW; c++) begin : g_col
      for (genvar f = 0; f < fa_count(WIDTH, l, c) + ha_count(WIDTH, l, c); f++) begin : g_cell
        logic cell_cin;
        logic cell_cout;
        if (f < fa_count(WIDTH, l, c)) begin : g_fa
          assign cell_cin = node[col_base(WIDTH, l, c) + 3*f + 2];
        end else begin : g_ha
          assign cell_cin = 1'b0;
        end
        full_adder u_cell (
          .a    (node[col_base(WIDTH, l, c) + 3*f]),
          .b    (node[col_base(WIDTH, l, c) + 3*f + 1]),
          .cin  (cell_cin),
          .sum  (node[col_base(WIDTH, l + 1, c) + f]),
          .cout (cell_cout)
        );
        if (c < PW - 1) begin : g_carry
          assign node[carry_slot(WIDTH, l, c) + f] = cell_cout;
        end else begin : g_drop
          logic unused_cout;
          assign unused_cout = cell_cout;
        end
      end
      for (genvar p = 3*fa_count(WIDTH, l, c) + 2*ha_count(WIDTH, l, c);
           p < col_height(WIDTH, l, c); p++) begin : g_pass
        assign node[col_base(WIDTH, l + 1, c) + fa_count(WIDTH, l, c) + ha_count(WIDTH, l, c)
                    + p - 3*fa_count(WIDTH, l, c) - 2*ha_count(WIDTH, l, c)]
               = node[col_base(WIDTH, l, c) + p];
      end
    end
  end

  logic [PW-1:0] row_a;
  logic [PW-1:0] row_b;
  logic [PW-1:0] chain;
  logic [PW-1:0] product;
  logic          unused_top_cout;

  assign chain[0] = 1'b0;

  // Columns of the last layer hold 0..2 bits; missing bits become zero operands.
  for (genvar c = 0; c < PW; c++) begin : g_final
    if (col_height(WIDTH, LAYERS, c) > 0) begin : g_a
      assign row_a[c] = node[col_base(WIDTH, LAYERS, c)];
    end else begin : g_a0
      assign row_a[c] = 1'b0;
    end
    if (col_height(WIDTH, LAYERS, c) > 1) begin : g_b
      assign row_b[c] = node[col_base(WIDTH, LAYERS, c) + 1];
    end else begin : g_b0
      assign row_b[c] = 1'b0;
    end
    if (c < PW - 1) begin : g_mid
      full_adder u_rca (
        .a(row_a[c]), .b(row_b[c]), .cin(chain[c]), .sum(product[c]), .cout(chain[c+1])
      );
    end else begin : g_top
      full_adder u_rca (
        .a(row_a[c]), .b(row_b[c]), .cin(chain[c]), .sum(product[c]), .cout(unused_top_cout)
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) P <= product;
    end
  end

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Bench for wallace_tree_multiplier (WIDTH=4): directed table, hold, exhaustive,
// random and mid-stream reset sequences against an arithmetic reference model.
module tb_wallace_tree_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          in_valid;
  logic [PW-1:0] P;
  logic          out_valid;

  int total = 0;
  int bad   = 0;

  // Reference state: last captured product and expected valid flag.
  int exp_p = 0;
  int exp_v = 0;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  vec_t dir_vecs[8];

  wallace_tree_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .P         (P),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Drive one operand pair, clock it in, then compare against the model.
  task automatic apply_stimulus(input int a, input int b, input int v);
    A        = W'(a);
    B        = W'(b);
    in_valid = (v != 0);
    if (v != 0) exp_p = a * b;
    exp_v = (v != 0) ? 1 : 0;
    @(posedge clk);
    #1;
    check_output("model_p", int'(P), exp_p);
    check_output("model_v", int'(out_valid), exp_v);
  endtask

  initial begin
    dir_vecs[0] = '{a: 1,  b: 1,  p: 8'b00000001};
    dir_vecs[1] = '{a: 2,  b: 2,  p: 8'b00000100};
    dir_vecs[2] = '{a: 3,  b: 3,  p: 8'b00001001};
    dir_vecs[3] = '{a: 5,  b: 7,  p: 8'b00100011};
    dir_vecs[4] = '{a: 15, b: 15, p: 8'hE1};
    dir_vecs[5] = '{a: 0,  b: 13, p: 8'h00};
    dir_vecs[6] = '{a: 15, b: 1,  p: 8'h0F};
    dir_vecs[7] = '{a: 8,  b: 8,  p: 8'h40};

    rst_n    = 1'b0;
    A        = 4'hF;
    B        = 4'hF;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_output("reset_p", int'(P), 0);
      check_output("reset_v", int'(out_valid), 0);
    end
    #3 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(dir_vecs[i].a, dir_vecs[i].b, 1);
      check_output("dir_p", int'(P), dir_vecs[i].p);
      check_output("dir_v", int'(out_valid), 1);
    end

    apply_stimulus(6, 9, 1);
    check_output("hold_cap", int'(P), 8'h36);
    A = 4'd1;
    B = 4'd1;
    #2;
    check_output("midcycle_p", int'(P), 8'h36);
    apply_stimulus(3, 2, 0);
    check_output("hold_p", int'(P), 8'h36);
    check_output("hold_v", int'(out_valid), 0);
    apply_stimulus(11, 12, 0);
    check_output("hold_p2", int'(P), 8'h36);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply_stimulus(a, b, 1);
        check_output("exh_p", int'(P), a * b);
      end
    end

    for (int k = 0; k < 300; k++) begin
      apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) != 0) ? 1 : 0);
    end

    apply_stimulus(5, 7, 1);
    check_output("mid_first", int'(P), 8'h23);
    A        = 4'd3;
    B        = 4'd3;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_clr_p", int'(P), 0);
    check_output("async_clr_v", int'(out_valid), 0);
    exp_p = 0;
    exp_v = 0;
    @(posedge clk);
    #1;
    check_output("in_reset_p", int'(P), 0);
    check_output("in_reset_v", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("released_p", int'(P), 0);
    apply_stimulus(3, 3, 1);
    check_output("after_rst_p", int'(P), 8'h09);
    check_output("after_rst_v", int'(out_valid), 1);
    apply_stimulus(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
